// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  // Bulk-clear sequencer states.
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 16;
  localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Bulk-clear sequencer: walks a counter over every entry, one per cycle,
// and reports busy while the sweep is running. Requests during a sweep
// are ignored. The current state is exported for observation.
module rf_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output rf_state_t         state,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_strobe
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         state_next;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_next;

  // State and sweep counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state, counter advance and clear strobe.
  always_comb begin
    state_next = state;
    count_next = count;
    clr_strobe = 1'b0;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_next = RF_CLEAR;
          count_next = '0;
        end
      end
      RF_CLEAR: begin
        clr_strobe = 1'b1;
        if (count == LAST) begin
          state_next = RF_IDLE;
          count_next = '0;
        end else begin
          count_next = count + ADDR_W'(1);
        end
      end
      default: state_next = RF_IDLE;
    endcase
  end

  assign clr_addr = count;
  assign clr_busy = (state == RF_CLEAR);

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file with NUM_RD registered read ports, one write
// port, a sequenced bulk clear and write-error reporting.
// Optional feature macro REGFILE_BYPASS_EN: when defined, an accepted write
// is forwarded to any port reading the same address on the same edge;
// otherwise reads are strictly read-before-write.
// Writes are accepted only while the clear sequencer is idle; an
// out-of-range address or a write during a sweep is rejected and flagged
// on W_err for one cycle. With ZERO_REG=1 entry 0 reads as 0 and writes
// to it are dropped silently.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              W_data,
  input  logic [ADDR_W-1:0]              W_addr,
  input  logic                           W_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  R_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  R_data,
  input  logic                           clr_req,
  output logic                           clr_busy,
  output logic                           W_err
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0]             mem [DEPTH];
  rf_state_t                     clr_state;
  logic [ADDR_W-1:0]             clr_addr;
  logic                          clr_strobe;
  logic                          w_in_range;
  logic                          w_zero;
  logic                          w_do;
  logic                          w_reject;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_next;

  rf_clear_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .state      (clr_state),
    .clr_busy   (clr_busy),
    .clr_addr   (clr_addr),
    .clr_strobe (clr_strobe)
  );

  assign w_in_range = int'(W_addr) < DEPTH;
  assign w_zero     = (ZERO_REG != 0) && (W_addr == '0);
  // A sweep takes priority over writes, so a write during CLEAR is an error
  // even if it targets a hardwired-zero entry.
  assign w_do       = W_en && w_in_range && (clr_state == RF_IDLE) && !w_zero;
  assign w_reject   = W_en && (!w_in_range || (clr_state != RF_IDLE));

  // Per-port read selection: out-of-range and hardwired zero read 0,
  // optional same-edge forwarding of an accepted write, else storage.
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ((int'(R_addr[p]) < DEPTH) && !((ZERO_REG != 0) && (R_addr[p] == '0))) begin
        if (BYPASS && w_do && (R_addr[p] == W_addr)) begin
          rd_next[p] = W_data;
        end else begin
          rd_next[p] = mem[R_addr[p]];
        end
      end
    end
  end

  // Storage: accepted writes and sweep zeroing never coincide because
  // writes are only accepted while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (w_do) begin
        mem[W_addr] <= W_data;
      end
      if (clr_strobe) begin
        mem[clr_addr] <= '0;
      end
    end
  end

  // Registered read data and write-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      R_data <= '0;
      W_err  <= 1'b0;
    end else begin
      R_data <= rd_next;
      W_err  <= w_reject;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a 16x16 two-port instance (dut_a) and a
// 12-entry four-port instance with hardwired zero (dut_b).
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- dut_a: 16 x 16, 2 ports ----------------
  logic [15:0]       a_wdata;
  logic [3:0]        a_waddr;
  logic              a_wen;
  logic [1:0][3:0]   a_raddr;
  logic [1:0][15:0]  a_rdata;
  logic              a_clr;
  logic              a_busy;
  logic              a_err;

  regfile_multiport #(
    .DATA_W(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(0)
  ) dut_a (
    .clk(clk), .rst(rst), .W_data(a_wdata), .W_addr(a_waddr), .W_en(a_wen),
    .R_addr(a_raddr), .R_data(a_rdata), .clr_req(a_clr), .clr_busy(a_busy),
    .W_err(a_err)
  );

  // ---------------- dut_b: 12 x 16, 4 ports, zero register ----------------
  logic [15:0]       b_wdata;
  logic [3:0]        b_waddr;
  logic              b_wen;
  logic [3:0][3:0]   b_raddr;
  logic [3:0][15:0]  b_rdata;
  logic              b_clr;
  logic              b_busy;
  logic              b_err;

  regfile_multiport #(
    .DATA_W(16), .DEPTH(12), .NUM_RD(4), .ZERO_REG(1)
  ) dut_b (
    .clk(clk), .rst(rst), .W_data(b_wdata), .W_addr(b_waddr), .W_en(b_wen),
    .R_addr(b_raddr), .R_data(b_rdata), .clr_req(b_clr), .clr_busy(b_busy),
    .W_err(b_err)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t vecs [8];

  // ---------------- reference model state ----------------
  logic [15:0] m_mem [16];
  int          clr_left;
  logic        r_we;
  logic [3:0]  r_wa;
  logic [15:0] r_wd;
  logic [3:0]  r_ra0;
  logic [3:0]  r_ra1;
  logic        r_clr;
  logic        r_acc;
  logic [15:0] r_e0;
  logic [15:0] r_e1;
  logic        r_eerr;
  int          busy_cycles;
  logic [15:0] same_exp;

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_wdata = '0; a_waddr = '0; a_wen = 1'b0; a_raddr = '0; a_clr = 1'b0;
    b_wdata = '0; b_waddr = '0; b_wen = 1'b0; b_raddr = '0; b_clr = 1'b0;

    vecs[0] = '{1'b1, 4'd5,  16'hBEEF, 4'd0,  4'd1,  16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd6,  16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 4'd3,  16'hAAAA, 4'd5,  4'd4,  16'hBEEF, 16'h0000};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd5,  16'hAAAA, 16'hBEEF};
    vecs[4] = '{1'b1, 4'd15, 16'hFFFF, 4'd14, 4'd3,  16'h0000, 16'hAAAA};
    vecs[5] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd14, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b1, 4'd5,  16'h0102, 4'd15, 4'd15, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd3,  16'h0102, 16'hAAAA};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_rdata0", 32'(a_rdata[0]), 32'h0);
    check("rst_a_rdata1", 32'(a_rdata[1]), 32'h0);
    check("rst_a_busy",   32'(a_busy),     32'h0);
    check("rst_a_err",    32'(a_err),      32'h0);
    check("rst_b_busy",   32'(b_busy),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 16; a += 2) begin
      a_raddr[0] = 4'(a);
      a_raddr[1] = 4'(a + 1);
      tick();
      check("rst_read_p0", 32'(a_rdata[0]), 32'h0);
      check("rst_read_p1", 32'(a_rdata[1]), 32'h0);
    end

    // ---- table-driven vectors ----
    for (int i = 0; i < 8; i++) begin
      a_wen      = vecs[i].we;
      a_waddr    = vecs[i].wa;
      a_wdata    = vecs[i].wd;
      a_raddr[0] = vecs[i].ra0;
      a_raddr[1] = vecs[i].ra1;
      tick();
      check("vec_rdata0", 32'(a_rdata[0]), 32'(vecs[i].e0));
      check("vec_rdata1", 32'(a_rdata[1]), 32'(vecs[i].e1));
      check("vec_err",    32'(a_err),      32'h0);
      check("vec_busy",   32'(a_busy),     32'h0);
    end
    a_wen = 1'b0;

    // ---- same-edge write and read of addr 3 (old value 0xAAAA) ----
    a_wen = 1'b1; a_waddr = 4'd3; a_wdata = 16'h1234;
    a_raddr[0] = 4'd3; a_raddr[1] = 4'd3;
    tick();
    a_wen = 1'b0;
    same_exp = BYPASS ? 16'h1234 : 16'hAAAA;
    check("same_edge_p0", 32'(a_rdata[0]), 32'(same_exp));
    check("same_edge_p1", 32'(a_rdata[1]), 32'(same_exp));
    tick();
    check("after_edge_p0", 32'(a_rdata[0]), 32'h1234);
    check("after_edge_p1", 32'(a_rdata[1]), 32'h1234);

    // ---- fill with i+1, then bulk clear with a rejected write ----
    for (int i = 0; i < 16; i++) begin
      a_wen = 1'b1; a_waddr = 4'(i); a_wdata = 16'(i + 1);
      tick();
    end
    a_wen = 1'b0;
    a_clr = 1'b1;
    a_raddr[0] = 4'd15;
    tick();
    busy_cycles = 0;
    for (int n = 1; n <= 40; n++) begin
      if (!a_busy) break;
      busy_cycles++;
      if (n == 2) check("sweep_pending_read", 32'(a_rdata[0]), 32'h10);
      if (n == 3) a_clr = 1'b0;
      if (n == 5) check("clear_write_err", 32'(a_err), 32'h1);
      if (n == 6) check("clear_err_pulse", 32'(a_err), 32'h0);
      a_wen   = (n == 4);
      a_waddr = 4'd2;
      a_wdata = 16'h5555;
      tick();
    end
    a_wen = 1'b0;
    check("clear_busy_cycles", 32'(busy_cycles), 32'd16);
    for (int a = 0; a < 16; a += 2) begin
      a_raddr[0] = 4'(a);
      a_raddr[1] = 4'(a + 1);
      tick();
      check("swept_p0", 32'(a_rdata[0]), 32'h0);
      check("swept_p1", 32'(a_rdata[1]), 32'h0);
    end
    check("swept_busy", 32'(a_busy), 32'h0);

    // ---- reset in the middle of a sweep ----
    for (int i = 8; i < 16; i++) begin
      a_wen = 1'b1; a_waddr = 4'(i); a_wdata = 16'(16'h100 + i);
      tick();
    end
    a_wen = 1'b0;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    tick();
    tick();
    check("midclr_busy_before", 32'(a_busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midclr_rst_busy",   32'(a_busy),     32'h0);
    check("midclr_rst_rdata0", 32'(a_rdata[0]), 32'h0);
    check("midclr_rst_rdata1", 32'(a_rdata[1]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 8; a < 16; a += 2) begin
      a_raddr[0] = 4'(a);
      a_raddr[1] = 4'(a + 1);
      tick();
      check("midclr_read_p0", 32'(a_rdata[0]), 32'h0);
      check("midclr_read_p1", 32'(a_rdata[1]), 32'h0);
    end
    check("midclr_busy_after", 32'(a_busy), 32'h0);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    for (int a = 0; a < 16; a++) begin
      // rebuild a known-zero start: the reset above cleared everything
      m_mem[a] = '0;
    end
    clr_left = 0;
    for (int c = 0; c < 400; c++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_wa  = 4'($urandom_range(0, 15));
      r_wd  = 16'($urandom_range(0, 65535));
      r_ra0 = 4'($urandom_range(0, 15));
      r_ra1 = (c % 5 == 0) ? r_wa : 4'($urandom_range(0, 15));
      r_clr = ($urandom_range(0, 24) == 0);
      // A write lands only when no sweep is pending; reads see the
      // contents before this edge unless forwarding supplies the write.
      r_acc  = r_we && (clr_left == 0);
      r_eerr = r_we && (clr_left > 0);
      r_e0   = (BYPASS && r_acc && (r_ra0 == r_wa)) ? r_wd : m_mem[r_ra0];
      r_e1   = (BYPASS && r_acc && (r_ra1 == r_wa)) ? r_wd : m_mem[r_ra1];
      if (r_acc) m_mem[r_wa] = r_wd;
      if (clr_left > 0) begin
        m_mem[16 - clr_left] = '0;
        clr_left--;
      end else if (r_clr) begin
        clr_left = 16;
      end
      a_wen = r_we; a_waddr = r_wa; a_wdata = r_wd;
      a_raddr[0] = r_ra0; a_raddr[1] = r_ra1; a_clr = r_clr;
      tick();
      check("rand_rdata0", 32'(a_rdata[0]), 32'(r_e0));
      check("rand_rdata1", 32'(a_rdata[1]), 32'(r_e1));
      check("rand_err",    32'(a_err),      32'(r_eerr));
      check("rand_busy",   32'(a_busy),     32'(clr_left > 0));
    end
    a_wen = 1'b0; a_clr = 1'b0;

    // ---- dut_b: hardwired zero, four ports, out-of-range write ----
    b_wen = 1'b1; b_waddr = 4'd0; b_wdata = 16'hFFFF;
    for (int p = 0; p < 4; p++) b_raddr[p] = 4'd0;
    tick();
    b_wen = 1'b0;
    tick();
    check("zero_write_err", 32'(b_err), 32'h0);
    for (int p = 0; p < 4; p++) check("zero_read", 32'(b_rdata[p]), 32'h0);

    b_wen = 1'b1; b_waddr = 4'd7; b_wdata = 16'h7777;
    tick();
    b_wen = 1'b0;
    for (int p = 0; p < 4; p++) b_raddr[p] = 4'd7;
    tick();
    for (int p = 0; p < 4; p++) check("multi_port_same", 32'(b_rdata[p]), 32'h7777);

    b_wen = 1'b1; b_waddr = 4'd13; b_wdata = 16'hDEAD;
    for (int p = 0; p < 4; p++) b_raddr[p] = 4'd13;
    tick();
    b_wen = 1'b0;
    check("oor_write_err", 32'(b_err), 32'h1);
    for (int p = 0; p < 4; p++) check("oor_read", 32'(b_rdata[p]), 32'h0);
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 4; p++) b_raddr[p] = 4'(k * 4 + p);
      tick();
      if (k == 0) check("oor_err_pulse", 32'(b_err), 32'h0);
      for (int p = 0; p < 4; p++) begin
        check("oor_unchanged", 32'(b_rdata[p]), (k * 4 + p == 7) ? 32'h7777 : 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised multi-read-port register file. It is the next generation of the datapath's 16x16, two-read-port register file. It adds configurable width, depth and read-port count, asynchronous reset, and an optional hardware-zero register 0. It also adds a sequenced bulk-clear engine with a busy flag, write-error reporting, and optional write-to-read forwarding. It sits between the instruction decoder (addresses, enables) and the ALU operand inputs.

## Interface
- DATA_W, 16, entry width in bits
- DEPTH, 16, number of entries (need not be a power of 2, minimum 2)
- ADDR_W, $clog2(DEPTH), address width
- NUM_RD, 2, number of read ports (1..8)
- ZERO_REG, 0, when 1 entry 0 always reads 0 and writes to it are discarded without error
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- W_data  in  DATA_W  write data
- W_addr  in  ADDR_W  write address
- W_en  in  1  write request
- R_addr  in  NUM_RD x ADDR_W  read address per port
- R_data  out  NUM_RD x DATA_W  registered read data per port
- clr_req  in  1  start bulk clear (level sampled each edge)
- clr_busy  out  1  bulk clear in progress
- W_err  out  1  one-cycle pulse: previous cycle's write was rejected

## Operation
- Reset (rst high, any time including mid-clear):
  - all entries become 0, every R_data 0, clr_busy 0, W_err 0
  - FSM goes to IDLE and the clear counter goes to 0
- Write: accepted at the rising edge when W_en=1, W_addr<DEPTH, and FSM is IDLE.
- Rejected write (W_addr>=DEPTH, or FSM in CLEAR): memory is unchanged and W_err=1 for the following cycle.
- Write to entry 0 with ZERO_REG=1: silently discarded, W_err stays 0.
- Read: each port independently registers the entry at R_addr on every edge.
  - R_addr>=DEPTH returns 0.
  - Entry 0 with ZERO_REG=1 returns 0.
- Ports reading the same address all return identical data.
- FSM states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req=1 at an edge; the counter loads 0.
  - In CLEAR, entry[counter] is zeroed at each edge and the counter increments.
  - CLEAR -> IDLE at the edge that clears entry DEPTH-1; the counter returns to 0.
  - clr_req during CLEAR is ignored (no restart, no queueing).
- A write in the same edge where clr_req is sampled in IDLE is accepted; the sweep later zeroes it.
- Reads remain serviced during CLEAR: an entry reads 0 once swept, its old value before that.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- clr_busy rises after the edge sampling clr_req and stays high exactly DEPTH cycles.
- W_err is registered: it is high for the cycle after the edge of the rejected write.
- Same-edge read and write to the same address:
  - without forwarding, R_data shows the old value (read-before-write)
  - the new value is visible one cycle later.
- Same-edge read of the entry being swept returns the pre-clear value (or the bypass value, if forwarding applies).

## Configuration
- REGFILE_BYPASS_EN defined: an accepted write is forwarded. Any port reading W_addr on the same edge registers W_data, so written data is visible with 1-cycle latency.
  - Rejected and ZERO_REG-discarded writes are never forwarded.
- REGFILE_BYPASS_EN undefined: strict read-before-write as in Timing.

## Structure
- Shared package regfile_pkg holds:
  - typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t
  - default constants RF_DATA_W=16, RF_DEPTH=16, RF_NUM_RD=2
- Sub-module rf_clear_ctrl holds the FSM, sweep counter, clr_busy, and the clear-address/clear-strobe outputs.
- Storage, read ports, forwarding and W_err logic live in regfile_multiport.

## Test plan
- Reset then read all 16 addresses on both ports -> every R_data 0; assert rst mid-clear -> clr_busy 0 immediately, all entries 0.
- Write 0xBEEF to addr 5, read addr 5 on port 0 and addr 6 on port 1 next cycle -> port 0 0xBEEF, port 1 0x0000.
- Same-edge write 0x1234 and read of addr 3 (old 0xAAAA) -> R_data 0xAAAA without REGFILE_BYPASS_EN, 0x1234 with it; 0x1234 in both builds one cycle later.
- Fill entries with i+1, pulse clr_req -> clr_busy high exactly 16 cycles; a write to addr 2 at cycle 4 -> W_err pulse, addr 2 reads 0 after sweep.
- DEPTH=12: write to addr 13 -> W_err=1 next cycle, read addr 13 -> 0, no entry changed.
- ZERO_REG=1: write 0xFFFF to addr 0 -> reads 0, W_err 0; NUM_RD=4 all reading addr 7 -> identical data.
